key_repeat_module: RTL

Debounces the two frequency-step push-buttons (KEY0 = add, KEY1 = subtract) and converts them into clean single-cycle step pulses, with hold-to-repeat, for the frequency-adjust stage of the DDS generator. Sits directly upstream of the DDS top: its pulse outputs drive the DDS `KW_Add_In` / `KW_Sub_In` inputs, so each pulse means exactly one tuning-word step. Raw key inputs are asynchronous and active-low (board buttons).

---
 rtl/key_repeat_module_if.sv | 21 ++
 rtl/key_repeat_module.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/key_repeat_module_if.sv
// Key inputs and step/level outputs of key_repeat_module.
// The master side drives the raw active-low keys; the slave side is the debouncer.
interface key_repeat_module_if;
   logic Key_Add_n;
   logic Key_Sub_n;
   logic KW_Add_Pulse;
   logic KW_Sub_Pulse;
   logic Key_Add_Level;
   logic Key_Sub_Level;
   logic Conflict;

   modport master (
      output Key_Add_n, Key_Sub_n,
      input  KW_Add_Pulse, KW_Sub_Pulse, Key_Add_Level, Key_Sub_Level, Conflict
   );

   modport slave (
      input  Key_Add_n, Key_Sub_n,
      output KW_Add_Pulse, KW_Sub_Pulse, Key_Add_Level, Key_Sub_Level, Conflict
   );
endinterface

// File: rtl/key_repeat_module.sv
// Debounces the add/subtract frequency keys and turns them into single-cycle
// step pulses with hold-to-repeat; index 0 is the add key, index 1 subtract.
module key_repeat_module #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000,
   parameter bit REPEAT_EN       = 1'b1
) (
   input logic                CLK,
   input logic                RST,
   key_repeat_module_if.slave keys
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int RD_W = $clog2(REPEAT_DELAY) + 1;
   localparam int RP_W = $clog2(REPEAT_PERIOD) + 1;
   localparam int RC_W = (RD_W > RP_W) ? RD_W : RP_W;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, HELD_DELAY, REPEAT} state_t;

   logic [1:0]      sync_p0;
   logic [1:0]      sync_p1;
   logic [1:0]      pressed;
   logic [DB_W-1:0] db_cnt    [2];
   logic [DB_W-1:0] db_cnt_nx [2];
   logic [1:0]      level;
   logic [1:0]      level_nx;
   state_t          state     [2];
   state_t          state_nx  [2];
   logic [RC_W-1:0] rep_cnt    [2];
   logic [RC_W-1:0] rep_cnt_nx [2];
   logic [1:0]      pulse;
   logic [1:0]      pulse_nx;
   logic            conflict;
   logic            conflict_nx;
   logic            hold;

   assign pressed = ~sync_p1;

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         db_cnt_nx[k] = '0;
         level_nx[k]  = level[k];
         if (pressed[k] != level[k]) begin
            if (db_cnt[k] == DB_LAST) begin
               level_nx[k] = ~level[k];
            end else begin
               db_cnt_nx[k] = db_cnt[k] + DB_W'(1);
            end
         end
      end
   end

   assign conflict_nx = &level_nx;
   // The release edge of a conflict still holds the counters, so the surviving key
   // restarts its delay from zero exactly like a fresh press.
   assign hold = conflict | conflict_nx;

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         state_nx[k]   = state[k];
         rep_cnt_nx[k] = rep_cnt[k];
         pulse_nx[k]   = 1'b0;
         if (!level_nx[k]) begin
            state_nx[k]   = IDLE;
            rep_cnt_nx[k] = '0;
         end else begin
            unique case (state[k])
               IDLE: begin
                  state_nx[k]   = HELD_DELAY;
                  rep_cnt_nx[k] = '0;
                  pulse_nx[k]   = 1'b1;
               end
               HELD_DELAY: begin
                  if (REPEAT_EN) begin
                     if (rep_cnt[k] == RD_LAST) begin
                        state_nx[k]   = REPEAT;
                        rep_cnt_nx[k] = '0;
                        pulse_nx[k]   = 1'b1;
                     end else begin
                        rep_cnt_nx[k] = rep_cnt[k] + RC_W'(1);
                     end
                  end else begin
                     rep_cnt_nx[k] = '0;
                  end
               end
               REPEAT: begin
                  if (rep_cnt[k] == RP_LAST) begin
                     rep_cnt_nx[k] = '0;
                     pulse_nx[k]   = 1'b1;
                  end else begin
                     rep_cnt_nx[k] = rep_cnt[k] + RC_W'(1);
                  end
               end
               default: begin
                  state_nx[k]   = IDLE;
                  rep_cnt_nx[k] = '0;
               end
            endcase
            if (hold) begin
               state_nx[k]   = HELD_DELAY;
               rep_cnt_nx[k] = '0;
               pulse_nx[k]   = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_p0  <= 2'b11;
         sync_p1  <= 2'b11;
         level    <= '0;
         pulse    <= '0;
         conflict <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            db_cnt[k]  <= '0;
            state[k]   <= IDLE;
            rep_cnt[k] <= '0;
         end
      end else begin
         // synchronizer stages
         sync_p0  <= {keys.Key_Sub_n, keys.Key_Add_n};
         sync_p1  <= sync_p0;
         level    <= level_nx;
         pulse    <= pulse_nx;
         conflict <= conflict_nx;
         for (int k = 0; k < 2; k++) begin
            db_cnt[k]  <= db_cnt_nx[k];
            state[k]   <= state_nx[k];
            rep_cnt[k] <= rep_cnt_nx[k];
         end
      end
   end

   assign keys.KW_Add_Pulse  = pulse[0];
   assign keys.KW_Sub_Pulse  = pulse[1];
   assign keys.Key_Add_Level = level[0];
   assign keys.Key_Sub_Level = level[1];
   assign keys.Conflict      = conflict;

endmodule
